// File: rtl/rtclock_pps_servo.sv
// PPS servo for the rtclock: measures the PPS period in clk cycles and steers the
// per-cycle time increment (Q8.24 ns) with a clamped proportional correction.
module rtclock_pps_servo #(
  parameter int unsigned CLK_FREQ_HZ   = 156250000,
  parameter logic [31:0] NOMINAL_DELTA = 32'h06666666,
  parameter int unsigned PPS_WINDOW    = 19531,
  parameter int unsigned KP_MULT       = 11,
  parameter int unsigned GAIN_SHIFT    = 4,
  parameter logic [31:0] MAX_ADJ       = 32'h00010000,
  parameter int unsigned LOCK_TOL      = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        pps_in,
  input  logic        delta_override_vld,
  input  logic [31:0] delta_override,
  output logic [31:0] delta_out,
  output logic        delta_valid,
  output logic [31:0] last_period,
  output logic [1:0]  servo_state,
  output logic        locked,
  output logic        pps_reject,
  output logic        pps_missing
);

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_ACQUIRE  = 2'd1,
    S_TRACK    = 2'd2,
    S_HOLDOVER = 2'd3
  } state_e;

  localparam logic [32:0] WIN_LO = 33'(CLK_FREQ_HZ) - 33'(PPS_WINDOW);
  localparam logic [32:0] WIN_HI = 33'(CLK_FREQ_HZ) + 33'(PPS_WINDOW);
  localparam logic signed [48:0] DELTA_LO = $signed({17'd0, NOMINAL_DELTA}) - $signed({17'd0, MAX_ADJ});
  localparam logic signed [48:0] DELTA_HI = $signed({17'd0, NOMINAL_DELTA}) + $signed({17'd0, MAX_ADJ});
  localparam logic signed [47:0] KP_S     = 48'(KP_MULT);

  state_e             state_q;
  logic [31:0]        cnt_q;
  logic [31:0]        delta_q;
  logic [31:0]        last_period_q;
  logic               delta_valid_q;
  logic               locked_q;
  logic               reject_q;
  logic               missing_q;
  logic               upd_q;
  logic               tol_q;
  logic               prev_tol_q;
  logic signed [47:0] adj_q;
  logic [2:0]         pps_sync_q;
  logic               edge_q;

  // Two flops resynchronise the pad; the third holds the previous level for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pps_sync_q <= '0;
      edge_q     <= 1'b0;
    end else begin
      pps_sync_q <= {pps_sync_q[1:0], pps_in};
      edge_q     <= pps_sync_q[1] & ~pps_sync_q[2];
    end
  end

  logic [32:0]        period;
  logic               in_window;
  logic               timeout;
  logic [31:0]        cnt_inc;
  logic [31:0]        err_u;
  logic [31:0]        err_abs;
  logic               in_tol;
  logic signed [47:0] err_s;
  logic signed [47:0] prod;
  logic signed [47:0] adj;
  logic signed [48:0] sum;
  logic [31:0]        delta_clamped;

  always_comb begin
    period        = {1'b0, cnt_q} + 33'd1;
    in_window     = (period >= WIN_LO) && (period <= WIN_HI);
    timeout       = (period == WIN_HI);
    cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
    err_u         = 32'(CLK_FREQ_HZ) - period[31:0];
    err_abs       = err_u[31] ? (~err_u + 32'd1) : err_u;
    in_tol        = err_abs <= 32'(LOCK_TOL);
    err_s         = {{16{err_u[31]}}, err_u};
    prod          = err_s * KP_S;
    adj           = prod >>> GAIN_SHIFT;
    sum           = $signed({17'd0, delta_q}) + {adj_q[47], adj_q};
    delta_clamped = sum[31:0];
    if (sum < DELTA_LO) delta_clamped = DELTA_LO[31:0];
    else if (sum > DELTA_HI) delta_clamped = DELTA_HI[31:0];
  end

  // NOTE: every state register here is assigned with <= so all of them update from
  // the same pre-edge values; blocking = would let later statements see new values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_DISABLED;
      cnt_q         <= '0;
      delta_q       <= NOMINAL_DELTA;
      last_period_q <= '0;
      delta_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      reject_q      <= 1'b0;
      missing_q     <= 1'b0;
      upd_q         <= 1'b0;
      tol_q         <= 1'b0;
      prev_tol_q    <= 1'b0;
      adj_q         <= '0;
    end else begin
      delta_valid_q <= 1'b0;
      reject_q      <= 1'b0;
      missing_q     <= 1'b0;
      upd_q         <= 1'b0;
      if (!enable) begin
        state_q    <= S_DISABLED;
        cnt_q      <= '0;
        locked_q   <= 1'b0;
        prev_tol_q <= 1'b0;
      end else begin
        case (state_q)
          S_DISABLED: begin
            state_q <= S_ACQUIRE;
            cnt_q   <= '0;
          end
          S_ACQUIRE, S_HOLDOVER: begin
            if (edge_q) begin
              state_q <= S_TRACK;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          S_TRACK: begin
            if (edge_q && in_window) begin
              last_period_q <= period[31:0];
              cnt_q         <= '0;
              adj_q         <= adj;
              tol_q         <= in_tol;
              upd_q         <= 1'b1;
            end else if (edge_q) begin
              reject_q <= 1'b1;
              cnt_q    <= cnt_inc;
            end else if (timeout) begin
              missing_q  <= 1'b1;
              locked_q   <= 1'b0;
              prev_tol_q <= 1'b0;
              state_q    <= S_HOLDOVER;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: state_q <= S_DISABLED;
        endcase
      end

      // A CPU override discards any update landing in the same cycle.
      if (delta_override_vld) begin
        delta_q       <= delta_override;
        delta_valid_q <= 1'b1;
      end else if (upd_q && enable) begin
        delta_q       <= delta_clamped;
        delta_valid_q <= 1'b1;
        locked_q      <= tol_q & prev_tol_q;
        prev_tol_q    <= tol_q;
      end
    end
  end

  assign delta_out   = delta_q;
  assign delta_valid = delta_valid_q;
  assign last_period = last_period_q;
  assign servo_state = state_q;
  assign locked      = locked_q;
  assign pps_reject  = reject_q;
  assign pps_missing = missing_q;

endmodule

// File: tb/tb_rtclock_pps_servo.sv
// Directed bench for rtclock_pps_servo: stimulus queues expected output pulses,
// a monitor pops and compares each time delta_valid, pps_reject or pps_missing fires.
module tb_rtclock_pps_servo;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        pps_in;
  logic        delta_override_vld;
  logic [31:0] delta_override;
  logic [31:0] delta_out;
  logic        delta_valid;
  logic [31:0] last_period;
  logic [1:0]  servo_state;
  logic        locked;
  logic        pps_reject;
  logic        pps_missing;

  rtclock_pps_servo #(
    .CLK_FREQ_HZ  (1000),
    .NOMINAL_DELTA(32'd1000),
    .PPS_WINDOW   (10),
    .KP_MULT      (1),
    .GAIN_SHIFT   (1),
    .MAX_ADJ      (32'd50),
    .LOCK_TOL     (2)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .enable            (enable),
    .pps_in            (pps_in),
    .delta_override_vld(delta_override_vld),
    .delta_override    (delta_override),
    .delta_out         (delta_out),
    .delta_valid       (delta_valid),
    .last_period       (last_period),
    .servo_state       (servo_state),
    .locked            (locked),
    .pps_reject        (pps_reject),
    .pps_missing       (pps_missing)
  );

  always #5 clk = ~clk;

  // Number of rising clk edges so far; stable when sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [2:0] F_VALID   = 3'b001;
  localparam logic [2:0] F_REJECT  = 3'b010;
  localparam logic [2:0] F_MISSING = 3'b100;

  typedef struct {
    int          cyc;
    logic [2:0]  flags;
    logic [31:0] delta;
    logic [31:0] period;
    logic [1:0]  state;
    logic        locked;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int c, input logic [2:0] f, input logic [31:0] d,
                              input logic [31:0] p, input logic [1:0] s, input logic l);
    exp_t e;
    e.cyc = c; e.flags = f; e.delta = d; e.period = p; e.state = s; e.locked = l;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Pad edge driven on the falling edge when cyc==n: edge detect after rising edge n+3,
  // FSM acts on rising edge n+4, delta update lands on rising edge n+5.
  task automatic pad(input int n);
    if (cyc > n) check("pad_schedule", cyc, n);
    wait_to(n);
    pps_in = 1'b1;
    repeat (4) @(negedge clk);
    pps_in = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (delta_valid || pps_reject || pps_missing) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got flags %0b delta %0d at cycle %0d, expected none",
                   {pps_missing, pps_reject, delta_valid}, delta_out, cyc);
        end else begin
          e = sb.pop_front();
          check("pulse_cycle",  cyc, e.cyc);
          check("pulse_flags",  {pps_missing, pps_reject, delta_valid}, e.flags);
          check("pulse_delta",  delta_out, e.delta);
          check("pulse_period", last_period, e.period);
          check("pulse_state",  servo_state, e.state);
          check("pulse_locked", locked, e.locked);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int p0, b, po, r;
    logic [31:0] d;
    resetn = 1'b0; enable = 1'b0; pps_in = 1'b0;
    delta_override_vld = 1'b0; delta_override = '0;
    repeat (3) @(negedge clk);
    check("rst_delta",   delta_out, 1000);
    check("rst_valid",   delta_valid, 0);
    check("rst_period",  last_period, 0);
    check("rst_state",   servo_state, 0);
    check("rst_locked",  locked, 0);
    check("rst_reject",  pps_reject, 0);
    check("rst_missing", pps_missing, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_disabled", servo_state, 0);
    enable = 1'b1;
    @(negedge clk);
    check("acquire_state", servo_state, 1);

    // Acquire then two nominal periods: zero error, lock after the second sample.
    p0 = 40;
    pad(p0);
    wait_to(p0 + 6);
    check("track_state", servo_state, 2);
    expect_pulse(p0 + 1005, F_VALID, 1000, 1000, 2, 0);
    pad(p0 + 1000);
    expect_pulse(p0 + 2005, F_VALID, 1000, 1000, 2, 1);
    pad(p0 + 2000);
    wait_to(p0 + 2006);
    check("locked_set", locked, 1);

    // Slow period: e=-4 -> p=-2, lock lost; then a rejected short period and a timeout.
    expect_pulse(p0 + 3009, F_VALID, 998, 1004, 2, 0);
    pad(p0 + 3004);
    expect_pulse(p0 + 3508, F_REJECT, 998, 1004, 2, 0);
    pad(p0 + 3504);
    expect_pulse(p0 + 4018, F_MISSING, 998, 1004, 3, 0);
    wait_to(p0 + 4020);
    check("holdover_state", servo_state, 3);
    pad(p0 + 4500);
    wait_to(p0 + 4506);
    check("reacq_state", servo_state, 2);
    check("reacq_delta", delta_out, 998);

    // Fast periods: e=+10 -> +5 per edge, clamped at 1050.
    b = p0 + 4500;
    for (int k = 1; k <= 12; k++) begin
      d = 998 + 5 * k;
      if (d > 1050) d = 1050;
      expect_pulse(b + 990 * k + 5, F_VALID, d, 990, 2, 0);
      pad(b + 990 * k);
    end

    // Override coinciding with the update cycle wins; later override is not clamped.
    po = b + 990 * 13;
    expect_pulse(po + 5, F_VALID, 1234, 990, 2, 0);
    pad(po);
    delta_override_vld = 1'b1; delta_override = 32'd1234;
    @(negedge clk);
    delta_override_vld = 1'b0;
    wait_to(po + 100);
    expect_pulse(po + 101, F_VALID, 0, 990, 2, 0);
    delta_override_vld = 1'b1; delta_override = 32'd0;
    @(negedge clk);
    delta_override_vld = 1'b0;

    // Asynchronous reset in the middle of a clock phase.
    wait_to(po + 200);
    check("pending_before_reset", sb.size(), 0);
    #2 resetn = 1'b0;
    #1;
    check("async_delta",  delta_out, 1000);
    check("async_period", last_period, 0);
    check("async_state",  servo_state, 0);
    check("async_locked", locked, 0);
    @(negedge clk);
    resetn = 1'b1;

    r = cyc + 5;
    pad(r);
    expect_pulse(r + 1005, F_VALID, 1000, 1000, 2, 0);
    pad(r + 1000);

    // Disable between acceptance and update: the pending update must not appear.
    pad(r + 2000);
    enable = 1'b0;
    wait_to(r + 2010);
    check("disabled_state", servo_state, 0);
    check("disabled_delta", delta_out, 1000);
    check("disabled_locked", locked, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
